alu_arbiter: RTL and testbench

Shares the single RV64I ALU between two requesters: req0 is the execute stage and req1 is the branch/address unit. Round-robin arbitration feeds a two-stage registered issue/response pipeline. The ALU itself stays a separate combinational instance driven by this block's alu_* ports. Throughput is one operation per cycle and latency is fixed at 2 cycles.

---
 rtl/alu_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational RV64I ALU between the execute stage (req0)
// and the branch/address unit (req1).
//
// A grant picks at most one requester per cycle; the accepted operation is captured
// in a registered issue stage, drives the external ALU for one cycle, and the ALU
// result is captured in a registered response stage. Accepted in cycle N, the
// response is presented in cycle N+2 for exactly one cycle. There is no response
// backpressure.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> req0 always wins contention (no rr_last state)
//                          undefined -> round-robin between the two requesters
//
// flush kills everything in flight: no transfer in the flush cycle, and the issue
// and response-valid registers clear at its end. A response already on the outputs
// during the flush cycle is left alone.

module alu_arbiter #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [FUNC_W-1:0] req0_function,
   input  logic [XLEN-1:0]   req0_operand_a,
   input  logic [XLEN-1:0]   req0_operand_b,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [FUNC_W-1:0] req1_function,
   input  logic [XLEN-1:0]   req1_operand_a,
   input  logic [XLEN-1:0]   req1_operand_b,

   output logic [FUNC_W-1:0] alu_function,
   output logic [XLEN-1:0]   alu_operand_a,
   output logic [XLEN-1:0]   alu_operand_b,
   input  logic [XLEN-1:0]   alu_result,
   input  logic              alu_result_eq_zero,

   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [XLEN-1:0]   rsp_result,
   output logic              rsp_zero
);

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   logic grant0;
   logic grant1;
   logic xfer0;
   logic xfer1;
   logic xfer_any;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: req1 only gets the ALU when req0 is idle.
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
   end
`else
   // rr_last_q holds the requester granted by the most recent transfer.
   // Resetting it to 1 lets req0 win the first contention.
   logic rr_last_q;
   logic rr_last_d;

   // Round-robin grant: on contention, favour the requester not granted last.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | rr_last_q);
      grant1 = req1_valid & (~req0_valid | ~rr_last_q);
   end

   // rr_last only moves on an actual transfer, so stalls and flushes keep fairness.
   always_comb begin
      rr_last_d = rr_last_q;
      if (xfer1) begin
         rr_last_d = 1'b1;
      end else if (xfer0) begin
         rr_last_d = 1'b0;
      end
   end

   // Round-robin history register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q <= 1'b1;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end
`endif

   // Ready is suppressed during flush and while reset is held so nothing is
   // accepted that the pipeline would immediately discard.
   assign req0_ready = grant0 & ~flush & rst_n;
   assign req1_ready = grant1 & ~flush & rst_n;

   // Grants are mutually exclusive and already qualified by valid.
   assign xfer0    = req0_ready;
   assign xfer1    = req1_ready;
   assign xfer_any = xfer0 | xfer1;

   // ------------------------------------------------------------------------
   // Issue stage
   // ------------------------------------------------------------------------
   logic              iss_valid_q;
   logic              iss_valid_d;
   logic              iss_owner_q;
   logic              iss_owner_d;
   logic [FUNC_W-1:0] iss_function_q;
   logic [FUNC_W-1:0] iss_function_d;
   logic [XLEN-1:0]   iss_a_q;
   logic [XLEN-1:0]   iss_a_d;
   logic [XLEN-1:0]   iss_b_q;
   logic [XLEN-1:0]   iss_b_d;

   // Capture the granted payload; the payload holds when idle since it is masked
   // at the ALU port anyway.
   always_comb begin
      iss_valid_d    = xfer_any;
      iss_owner_d    = iss_owner_q;
      iss_function_d = iss_function_q;
      iss_a_d        = iss_a_q;
      iss_b_d        = iss_b_q;
      if (xfer1) begin
         iss_owner_d    = 1'b1;
         iss_function_d = req1_function;
         iss_a_d        = req1_operand_a;
         iss_b_d        = req1_operand_b;
      end else if (xfer0) begin
         iss_owner_d    = 1'b0;
         iss_function_d = req0_function;
         iss_a_d        = req0_operand_a;
         iss_b_d        = req0_operand_b;
      end
   end

   // Issue-stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid_q    <= 1'b0;
         iss_owner_q    <= 1'b0;
         iss_function_q <= '0;
         iss_a_q        <= '0;
         iss_b_q        <= '0;
      end else begin
         iss_valid_q    <= iss_valid_d;
         iss_owner_q    <= iss_owner_d;
         iss_function_q <= iss_function_d;
         iss_a_q        <= iss_a_d;
         iss_b_q        <= iss_b_d;
      end
   end

   // Idle ALU inputs are forced to zero so the shared ALU does not toggle.
   assign alu_function  = iss_valid_q ? iss_function_q : '0;
   assign alu_operand_a = iss_valid_q ? iss_a_q        : '0;
   assign alu_operand_b = iss_valid_q ? iss_b_q        : '0;

   // ------------------------------------------------------------------------
   // Response stage
   // ------------------------------------------------------------------------
   logic            rsp_fire;
   logic            rsp0_valid_q;
   logic            rsp0_valid_d;
   logic            rsp1_valid_q;
   logic            rsp1_valid_d;
   logic [XLEN-1:0] rsp_result_q;
   logic [XLEN-1:0] rsp_result_d;
   logic            rsp_zero_q;
   logic            rsp_zero_d;

   // A flush in the issue cycle kills the operation before it produces a response;
   // the result registers then keep their last value.
   always_comb begin
      rsp_fire     = iss_valid_q & ~flush;
      rsp0_valid_d = rsp_fire & ~iss_owner_q;
      rsp1_valid_d = rsp_fire & iss_owner_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      if (rsp_fire) begin
         rsp_result_d = alu_result;
         rsp_zero_d   = alu_result_eq_zero;
      end
   end

   // Response-stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A behavioural RV64I ALU closes the loop on
// the alu_* ports. A scoreboard process predicts grants from the arbitration rules
// and responses from a queue of {due cycle, owner, result}; scenario tasks add
// directed checks on top.

module tb_alu_arbiter;
   localparam int unsigned XLEN   = 64;
   localparam int unsigned FUNC_W = 4;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              req0_valid;
   logic              req0_ready;
   logic [FUNC_W-1:0] req0_function;
   logic [XLEN-1:0]   req0_operand_a;
   logic [XLEN-1:0]   req0_operand_b;
   logic              req1_valid;
   logic              req1_ready;
   logic [FUNC_W-1:0] req1_function;
   logic [XLEN-1:0]   req1_operand_a;
   logic [XLEN-1:0]   req1_operand_b;
   logic [FUNC_W-1:0] alu_function;
   logic [XLEN-1:0]   alu_operand_a;
   logic [XLEN-1:0]   alu_operand_b;
   logic [XLEN-1:0]   alu_result;
   logic              alu_result_eq_zero;
   logic              rsp0_valid;
   logic              rsp1_valid;
   logic [XLEN-1:0]   rsp_result;
   logic              rsp_zero;

   alu_arbiter #(.XLEN(XLEN), .FUNC_W(FUNC_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush             (flush),
      .req0_valid        (req0_valid),
      .req0_ready        (req0_ready),
      .req0_function     (req0_function),
      .req0_operand_a    (req0_operand_a),
      .req0_operand_b    (req0_operand_b),
      .req1_valid        (req1_valid),
      .req1_ready        (req1_ready),
      .req1_function     (req1_function),
      .req1_operand_a    (req1_operand_a),
      .req1_operand_b    (req1_operand_b),
      .alu_function      (alu_function),
      .alu_operand_a     (alu_operand_a),
      .alu_operand_b     (alu_operand_b),
      .alu_result        (alu_result),
      .alu_result_eq_zero(alu_result_eq_zero),
      .rsp0_valid        (rsp0_valid),
      .rsp1_valid        (rsp1_valid),
      .rsp_result        (rsp_result),
      .rsp_zero          (rsp_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RV64I ALU, function = {alt, funct3}.
   function automatic logic [63:0] ref_alu(input logic [3:0] f, input logic [63:0] a,
                                           input logic [63:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [5:0]         sh;
      sa = a;
      sb = b;
      sh = b[5:0];
      case (f[2:0])
         3'd0: ref_alu = f[3] ? a - b : a + b;
         3'd1: ref_alu = a << sh;
         3'd2: ref_alu = (sa < sb) ? 64'd1 : 64'd0;
         3'd3: ref_alu = (a < b) ? 64'd1 : 64'd0;
         3'd4: ref_alu = a ^ b;
         3'd5: ref_alu = f[3] ? 64'(sa >>> sh) : a >> sh;
         3'd6: ref_alu = a | b;
         3'd7: ref_alu = a & b;
      endcase
   endfunction

   assign alu_result         = ref_alu(alu_function, alu_operand_a, alu_operand_b);
   assign alu_result_eq_zero = (alu_result == 64'd0);

   // ------------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------------
   typedef struct {
      int          due;
      logic        owner;
      logic [63:0] res;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fails  = 0;
   int          cyc      = 0;
   logic        model_last;
   logic [63:0] exp_res;
   logic        exp_zero;
   logic        prev_valid;
   logic [3:0]  prev_func;
   logic [63:0] prev_a;
   logic [63:0] prev_b;
   logic        e0;
   logic        e1;
   logic        has;
   logic        ev0;
   logic        ev1;
   logic        xfer0;
   logic        xfer1;
   logic [3:0]  x_func;
   logic [63:0] x_a;
   logic [63:0] x_b;

   function automatic void sb_reset();
      exp_q.delete();
      model_last = 1'b1;
      exp_res    = 64'd0;
      exp_zero   = 1'b0;
      prev_valid = 1'b0;
      prev_func  = 4'd0;
      prev_a     = 64'd0;
      prev_b     = 64'd0;
   endfunction

   initial begin : scoreboard
      sb_reset();
      xfer0 = 1'b0;
      xfer1 = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) sb_reset();
         e0 = 1'b0;
         e1 = 1'b0;
         if (rst_n && !flush) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
               e0 = 1'b1;
`else
               if (model_last) e0 = 1'b1;
               else            e1 = 1'b1;
`endif
            end else begin
               e0 = req0_valid;
               e1 = req1_valid;
            end
         end
         n_checks++;
         if (req0_ready !== e0) begin
            n_fails++;
            $display("FAIL sb_ready0 cycle %0d: got %b expected %b", cyc, req0_ready, e0);
         end
         n_checks++;
         if (req1_ready !== e1) begin
            n_fails++;
            $display("FAIL sb_ready1 cycle %0d: got %b expected %b", cyc, req1_ready, e1);
         end
         has = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         ev0 = has && !exp_q[0].owner;
         ev1 = has && exp_q[0].owner;
         if (has) begin
            exp_res  = exp_q[0].res;
            exp_zero = (exp_q[0].res == 64'd0);
            void'(exp_q.pop_front());
         end
         n_checks++;
         if ({rsp0_valid, rsp1_valid} !== {ev0, ev1}) begin
            n_fails++;
            $display("FAIL sb_rsp_valid cycle %0d: got %b%b expected %b%b", cyc,
                     rsp0_valid, rsp1_valid, ev0, ev1);
         end
         n_checks++;
         if (rsp_result !== exp_res || rsp_zero !== exp_zero) begin
            n_fails++;
            $display("FAIL sb_rsp_data cycle %0d: got %h/%b expected %h/%b", cyc,
                     rsp_result, rsp_zero, exp_res, exp_zero);
         end
         n_checks++;
         if (alu_function !== (prev_valid ? prev_func : 4'd0) ||
             alu_operand_a !== (prev_valid ? prev_a : 64'd0) ||
             alu_operand_b !== (prev_valid ? prev_b : 64'd0)) begin
            n_fails++;
            $display("FAIL sb_alu_drive cycle %0d: got %h/%h/%h expected valid=%b %h/%h/%h",
                     cyc, alu_function, alu_operand_a, alu_operand_b, prev_valid,
                     prev_func, prev_a, prev_b);
         end
         xfer0  = req0_valid && e0;
         xfer1  = req1_valid && e1;
         x_func = xfer1 ? req1_function  : req0_function;
         x_a    = xfer1 ? req1_operand_a : req0_operand_a;
         x_b    = xfer1 ? req1_operand_b : req0_operand_b;
         @(posedge clk);
         if (!rst_n) begin
            sb_reset();
         end else begin
            // A flush this cycle kills the operation that would respond next cycle.
            if (flush) begin
               for (int i = exp_q.size() - 1; i >= 0; i--) begin
                  if (exp_q[i].due == cyc + 1) exp_q.delete(i);
               end
            end
            if (xfer0 || xfer1) begin
               exp_q.push_back('{due: cyc + 2, owner: xfer1, res: ref_alu(x_func, x_a, x_b)});
               model_last = xfer1;
            end
            prev_valid = xfer0 || xfer1;
            prev_func  = x_func;
            prev_a     = x_a;
            prev_b     = x_b;
         end
         cyc++;
      end
   end

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({rsp0_valid, rsp1_valid, rsp_zero} !== 3'b000 || rsp_result !== 64'd0) begin
         n_fails++;
         $display("FAIL reset_rsp: got %b%b%b %h expected 000 0", rsp0_valid, rsp1_valid,
                  rsp_zero, rsp_result);
      end
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b00 || alu_function !== 4'd0 ||
          alu_operand_a !== 64'd0 || alu_operand_b !== 64'd0) begin
         n_fails++;
         $display("FAIL reset_ready_alu: got %b%b %h %h %h expected all zero", req0_ready,
                  req1_ready, alu_function, alu_operand_a, alu_operand_b);
      end
      repeat (3) tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_op();
      req0_function  = 4'b0000;
      req0_operand_a = 64'd5;
      req0_operand_b = 64'd7;
      req0_valid     = 1'b1;
      tick();
      n_checks++;
      if (xfer0 !== 1'b1) begin
         n_fails++;
         $display("FAIL single_accept: got %b expected 1", xfer0);
      end
      req0_valid = 1'b0;
      tick();
      n_checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_result !== 64'd12 || rsp_zero !== 1'b0)
      begin
         n_fails++;
         $display("FAIL single_rsp: got %b%b %h %b expected 10 c 0", rsp0_valid, rsp1_valid,
                  rsp_result, rsp_zero);
      end
      tick();
      n_checks++;
      if (rsp0_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL single_pulse: got %b expected 0", rsp0_valid);
      end
   endtask

   task automatic test_contention();
      logic       order [4];
      logic       exp_order [4];
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req0_function  = 4'b1000;
      req0_operand_a = 64'd9;
      req0_operand_b = 64'd9;
      req1_function  = 4'b0111;
      req1_operand_a = 64'hF0;
      req1_operand_b = 64'h3C;
      req0_valid     = 1'b1;
      req1_valid     = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
         tick();
         if (i < 4) begin
            order[i] = xfer1;
            n_checks++;
            if (order[i] !== exp_order[i] || (xfer0 ^ xfer1) !== 1'b1) begin
               n_fails++;
               $display("FAIL contention_grant[%0d]: got x0=%b x1=%b expected owner %b", i,
                        xfer0, xfer1, exp_order[i]);
            end
         end
         if (i >= 1) begin
            n_checks++;
            if (exp_order[i-1] == 1'b0 ? ({rsp0_valid, rsp1_valid, rsp_zero} !== 3'b101 ||
                                          rsp_result !== 64'd0)
                                       : ({rsp0_valid, rsp1_valid, rsp_zero} !== 3'b010 ||
                                          rsp_result !== 64'h30)) begin
               n_fails++;
               $display("FAIL contention_rsp[%0d]: got %b%b %h z=%b for owner %b", i - 1,
                        rsp0_valid, rsp1_valid, rsp_result, rsp_zero, exp_order[i-1]);
            end
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      req0_valid     = 1'b0;
      req1_function  = 4'b0001;
      req1_operand_a = 64'd1;
      req1_operand_b = 64'd63;
      req1_valid     = 1'b1;
      tick();
      req1_operand_b = 64'd64;
      tick();
      req1_valid = 1'b0;
      n_checks++;
      if (rsp1_valid !== 1'b1 || rsp_result !== 64'h8000_0000_0000_0000 || rsp_zero !== 1'b0)
      begin
         n_fails++;
         $display("FAIL b2b_first: got %b %h %b expected 1 8000000000000000 0", rsp1_valid,
                  rsp_result, rsp_zero);
      end
      tick();
      n_checks++;
      if (rsp1_valid !== 1'b1 || rsp_result !== 64'd1) begin
         n_fails++;
         $display("FAIL b2b_second: got %b %h expected 1 1", rsp1_valid, rsp_result);
      end
      tick();
   endtask

   task automatic test_flush();
      req1_valid     = 1'b0;
      req0_function  = 4'b0000;
      req0_operand_a = 64'd3;
      req0_operand_b = 64'd4;
      req0_valid     = 1'b1;
      tick();
      req0_operand_a = 64'd10;
      req0_operand_b = 64'd20;
      flush = 1'b1;
      tick();
      n_checks++;
      if (xfer0 !== 1'b0) begin
         n_fails++;
         $display("FAIL flush_no_accept: got %b expected 0", xfer0);
      end
      flush = 1'b0;
      req0_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_fails++;
            $display("FAIL flush_suppress[%0d]: got %b%b expected 00", i, rsp0_valid,
                     rsp1_valid);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      req0_function  = 4'b0000;
      req0_operand_a = 64'd100;
      req0_operand_b = 64'd23;
      req0_valid     = 1'b1;
      tick();
      req0_operand_a = 64'd200;
      req0_operand_b = 64'd1;
      tick();
      n_checks++;
      if (rsp0_valid !== 1'b1 || rsp_result !== 64'd123) begin
         n_fails++;
         $display("FAIL areset_pre: got %b %h expected 1 7b", rsp0_valid, rsp_result);
      end
      req1_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({rsp0_valid, rsp1_valid, rsp_zero} !== 3'b000 || rsp_result !== 64'd0 ||
          alu_function !== 4'd0 || alu_operand_a !== 64'd0 || alu_operand_b !== 64'd0 ||
          {req0_ready, req1_ready} !== 2'b00) begin
         n_fails++;
         $display("FAIL areset_now: got rsp %b%b %h %b alu %h %h %h rdy %b%b expected zero",
                  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, alu_function, alu_operand_a,
                  alu_operand_b, req0_ready, req1_ready);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (xfer0 !== 1'b1 || xfer1 !== 1'b0) begin
         n_fails++;
         $display("FAIL areset_first_grant: got x0=%b x1=%b expected 1 0", xfer0, xfer1);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) tick();
   endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (xfer0 !== 1'b1 || xfer1 !== 1'b0) begin
            n_fails++;
            $display("FAIL fixed_prio[%0d]: got x0=%b x1=%b expected 1 0", i, xfer0, xfer1);
         end
      end
      req0_valid = 1'b0;
      tick();
      n_checks++;
      if (xfer1 !== 1'b1) begin
         n_fails++;
         $display("FAIL fixed_prio_req1: got %b expected 1", xfer1);
      end
      req1_valid = 1'b0;
      repeat (3) tick();
   endtask
`endif

   task automatic test_random(input int n);
      for (int i = 0; i < n; i++) begin
         // Payload may change only when idle or right after a transfer.
         if (!req0_valid || xfer0) begin
            req0_valid     = ($urandom_range(0, 3) != 0);
            req0_function  = 4'($urandom_range(0, 15));
            req0_operand_a = {$urandom, $urandom};
            req0_operand_b = ($urandom_range(0, 3) == 0) ? req0_operand_a : {$urandom, $urandom};
         end
         if (!req1_valid || xfer1) begin
            req1_valid     = ($urandom_range(0, 2) != 0);
            req1_function  = 4'($urandom_range(0, 15));
            req1_operand_a = {$urandom, $urandom};
            req1_operand_b = ($urandom_range(0, 3) == 0) ? req1_operand_a : {$urandom, $urandom};
         end
         flush = ($urandom_range(0, 9) == 0);
         tick();
      end
      flush      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) tick();
   endtask

   initial begin : main
      rst_n          = 1'b1;
      flush          = 1'b0;
      req0_valid     = 1'b0;
      req0_function  = '0;
      req0_operand_a = '0;
      req0_operand_b = '0;
      req1_valid     = 1'b0;
      req1_function  = '0;
      req1_operand_a = '0;
      req1_operand_b = '0;
      test_reset();
      test_single_op();
      test_contention();
      test_back_to_back();
      test_flush();
      test_async_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      test_random(400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
